cmos_pattern_gen: RTL and testbench
===================================

# cmos_pattern_gen

Synthesizable, parametrised camera-stream source producing the same VSYNC/HREF/CLKEN/DATA video interface that feeds `haze_removal_top`. It generalises the behavioural camera model to arbitrary resolution, blanking, channel count, channel width and pixel-rate divider. It adds runtime-selectable test patterns and a frame counter. It sits in front of the processing chain, on FPGA for bring-up and in simulation as a file-free stimulus.

## Interface
- `IMG_HDISP`, 640: active pixels per line.
- `IMG_VDISP`, 480: active lines per frame.
- `H_BLANK`, 160: blank cycles per line, HREF low.
- `V_SYNC`, 2: lines with VSYNC high.
- `V_BP`, 20: blank lines after VSYNC.
- `V_FP`, 10: blank lines after the active region.
- `CH_NUM`, 3: colour channels.
- `CH_WIDTH`, 8: bits per channel.
- `CLKEN_DIV`, 1: one pixel every CLKEN_DIV cycles inside HREF, 1..16.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request.
- `mode`  in  2  pattern select, latched at frame start.
- `solid_color`  in  CH_NUM*CH_WIDTH  constant for mode 3, latched at frame start.
- `CMOS_VSYNC`  out  1  frame sync, active high.
- `CMOS_HREF`  out  1  active-line window.
- `CMOS_CLKEN`  out  1  pixel valid.
- `CMOS_DATA`  out  CH_NUM*CH_WIDTH  pixel; channel CH_NUM-1 in the MSBs.
- `X_POS`  out  16  active pixel column.
- `Y_POS`  out  16  active line row.
- `frame_cnt`  out  16  completed frames, wraps at 65535→0.

## Operation
- State machine with five states: IDLE, VSYNC, VBP, ACTIVE, VFP.
- Line length is L = H_BLANK + IMG_HDISP*CLKEN_DIV cycles. Counter `hcnt` runs 0..L-1 and `vcnt` counts lines within the current state.
- IDLE: all outputs low. When `enable`=1 at a clock edge, the block latches `mode` and `solid_color` and enters VSYNC.
- VSYNC: VSYNC high for V_SYNC·L cycles, then VBP.
- VBP: V_BP·L blank cycles, then ACTIVE.
- ACTIVE: IMG_VDISP lines, then VFP. In each line, `hcnt` < H_BLANK gives HREF low; the remainder gives HREF high.
  - CLKEN is high on the first cycle of each CLKEN_DIV-cycle group within HREF.
  - X_POS increments after each CLKEN and resets to 0 at each line start.
  - Y_POS increments per active line.
- VFP: V_FP·L blank cycles. Then `frame_cnt` increments. If `enable`=1, the block latches `mode`/`solid_color` and enters VSYNC; otherwise it enters IDLE.
- Dropping `enable` mid-frame has no effect until the frame completes. Changes to `mode` mid-frame are ignored.
- Patterns, with x=X_POS, y=Y_POS, c=channel index, M=2^CH_WIDTH-1:
  - mode 0, bars: b = (x*8)/IMG_HDISP (integer). Channel c = M if bit (c mod 3) of (7-b) is 1, else 0.
  - mode 1, gradient: every channel = (x+y) mod 2^CH_WIDTH.
  - mode 2, counter: per-frame pixel counter p starts at 0 each frame and increments per CLKEN. Channel c = (p+c) mod 2^CH_WIDTH.
  - mode 3, solid: latched `solid_color`.
- CMOS_DATA is 0 whenever CLKEN=0.

## Timing
- All outputs are registered. Reset value is 0 for every output. State is IDLE.
- Asserting `rst` at any time clears everything immediately, including mid-line.
- CMOS_VSYNC rises one cycle after the first edge that samples `enable`=1 in IDLE.
- HREF, CLKEN, DATA, X_POS and Y_POS are mutually aligned in the same cycle.
- Frame period is (V_SYNC+V_BP+IMG_VDISP+V_FP)·L cycles. Back-to-back frames have no extra gap.
- `frame_cnt` updates in the cycle after the last VFP cycle.

## Configuration
- `PATTERN_GEN_CHECKSUM_EN`:
  - Defined: adds an output `frame_checksum` [31:0], which is the modulo-2^32 sum of every CMOS_DATA word with CLKEN=1 in a frame. It is registered together with the `frame_cnt` update, and the accumulator clears at VSYNC entry. Reset value is 0.
  - Undefined: the port and logic are absent.

## Test plan
Common setup: IMG_HDISP=16, IMG_VDISP=4, H_BLANK=4, V_SYNC=1, V_BP=2, V_FP=1, CLKEN_DIV=1, CH_NUM=3, CH_WIDTH=8. This gives L=20 and a frame of 160 cycles.
- Reset, then hold `enable`=1 with mode 0:
  - VSYNC rises one cycle after the enable edge and stays high 20 cycles.
  - First HREF starts at cycle 64.
  - 64 CLKENs per frame.
  - Pixels x=0,1 = 0xFFFFFF; x=2 = 0xFFFF00; x=14,15 = 0x000000.
- Mode 2 for two frames:
  - First pixel 0x020100, last pixel 0x41403F in each frame.
  - `frame_cnt` is 1 then 2.
  - Checksum (with `PATTERN_GEN_CHECKSUM_EN`) identical for both frames.
- CLKEN_DIV=3:
  - HREF lasts 48 cycles.
  - CLKEN pulses every third cycle, 16 per line.
  - DATA is 0 between pulses.
- Drop `enable` at cycle 80 of a frame:
  - The frame completes through VFP, `frame_cnt` increments, and the block returns to IDLE with outputs 0.
  - Change `mode` mid-frame: no pattern change until the next frame.
- Assert `rst` mid-ACTIVE:
  - All outputs 0 in the same cycle.
  - After release with `enable`=1, a complete new frame starts with `frame_cnt`=0.
- Mode 3 with `solid_color`=0x123456: every CLKEN pixel = 0x123456; checksum = 64·0x123456 = 0x048D1580.

Source files
------------

// File: rtl/cmos_pattern_gen.sv
// Parametrised camera-stream source (VSYNC/HREF/CLKEN/DATA) with selectable test patterns.
// Latency: every output is registered one cycle behind the internal line/frame counters.
// Backpressure: none; free-running once started, a frame always runs to completion.
//
// Ports:
//   clk, rst (async active-high), enable (run request)
//   mode[1:0]    : 0 bars, 1 gradient, 2 pixel counter, 3 solid (latched at frame start)
//   solid_color  : constant for mode 3 (latched at frame start)
//   CMOS_VSYNC / CMOS_HREF / CMOS_CLKEN / CMOS_DATA : video stream, channel CH_NUM-1 in MSBs
//   X_POS / Y_POS : active pixel column / line row
//   frame_cnt     : completed frames, wraps
//   frame_checksum: only when PATTERN_GEN_CHECKSUM_EN is defined; mod-2^32 sum of the
//                   CLKEN pixels of the last completed frame
module cmos_pattern_gen #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_BLANK   = 160,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 20,
    parameter int V_FP      = 10,
    parameter int CH_NUM    = 3,
    parameter int CH_WIDTH  = 8,
    parameter int CLKEN_DIV = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    input  logic [CH_NUM*CH_WIDTH-1:0] solid_color,
    output logic                       CMOS_VSYNC,
    output logic                       CMOS_HREF,
    output logic                       CMOS_CLKEN,
    output logic [CH_NUM*CH_WIDTH-1:0] CMOS_DATA,
    output logic [15:0]                X_POS,
    output logic [15:0]                Y_POS,
    output logic [15:0]                frame_cnt
`ifdef PATTERN_GEN_CHECKSUM_EN
    ,
    output logic [31:0]                frame_checksum
`endif
);

    localparam int          DW        = CH_NUM * CH_WIDTH;
    localparam int          LINE_LEN  = H_BLANK + IMG_HDISP * CLKEN_DIV;
    localparam logic [15:0] H_LAST    = 16'(LINE_LEN - 1);
    localparam logic [15:0] H_BLANK_W = 16'(H_BLANK);
    localparam logic [15:0] VS_LAST   = 16'(V_SYNC - 1);
    localparam logic [15:0] VBP_LAST  = 16'(V_BP - 1);
    localparam logic [15:0] VACT_LAST = 16'(IMG_VDISP - 1);
    localparam logic [15:0] VFP_LAST  = 16'(V_FP - 1);
    localparam logic [4:0]  DIV_LAST  = 5'(CLKEN_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } state_t;

    state_t              state_q;
    logic [15:0]         hcnt_q;
    logic [15:0]         vcnt_q;
    logic [15:0]         x_q;
    logic [15:0]         y_q;
    logic [4:0]          div_q;
    logic [CH_WIDTH-1:0] p_q;
    logic [1:0]          mode_q;
    logic [DW-1:0]       solid_q;
    logic                done_q;
`ifdef PATTERN_GEN_CHECKSUM_EN
    logic [31:0]         acc_q;
`endif

    logic                line_end_d;
    logic                last_line_d;
    logic                href_d;
    logic                clken_d;
    logic                frame_end_d;
    logic                start_d;
    logic [15:0]         vlim_d;
    logic [2:0]          bar_idx_d;
    logic [2:0]          bar_code_d;
    logic [CH_WIDTH-1:0] grad_d;
    logic [DW-1:0]       pix_d;

    // Last line index of the current vertical region.
    always_comb begin
        vlim_d = VFP_LAST;
        case (state_q)
            ST_VSYNC:  vlim_d = VS_LAST;
            ST_VBP:    vlim_d = VBP_LAST;
            ST_ACTIVE: vlim_d = VACT_LAST;
            default:   vlim_d = VFP_LAST;
        endcase
    end

    assign line_end_d  = (hcnt_q == H_LAST);
    assign last_line_d = (vcnt_q == vlim_d);
    assign href_d      = (state_q == ST_ACTIVE) && (hcnt_q >= H_BLANK_W);
    assign clken_d     = href_d && (div_q == 5'd0);
    assign frame_end_d = (state_q == ST_VFP) && line_end_d && last_line_d;
    // A new frame starts from IDLE or directly off the last VFP cycle (no gap).
    assign start_d     = enable && ((state_q == ST_IDLE) || frame_end_d);

    assign bar_idx_d  = 3'(({16'd0, x_q} * 32'd8) / 32'(IMG_HDISP));
    assign bar_code_d = 3'd7 - bar_idx_d;
    assign grad_d     = CH_WIDTH'(x_q + y_q);

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        assign pix_d[c*CH_WIDTH +: CH_WIDTH] =
            (mode_q == 2'd0) ? (bar_code_d[c % 3] ? {CH_WIDTH{1'b1}} : {CH_WIDTH{1'b0}}) :
            (mode_q == 2'd1) ? grad_d :
            (mode_q == 2'd2) ? p_q + CH_WIDTH'(c) :
                               solid_q[c*CH_WIDTH +: CH_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            div_q      <= '0;
            p_q        <= '0;
            mode_q     <= '0;
            solid_q    <= '0;
            done_q     <= 1'b0;
            CMOS_VSYNC <= 1'b0;
            CMOS_HREF  <= 1'b0;
            CMOS_CLKEN <= 1'b0;
            CMOS_DATA  <= '0;
            X_POS      <= '0;
            Y_POS      <= '0;
            frame_cnt  <= '0;
`ifdef PATTERN_GEN_CHECKSUM_EN
            acc_q          <= '0;
            frame_checksum <= '0;
`endif
        end else begin
            CMOS_VSYNC <= (state_q == ST_VSYNC);
            CMOS_HREF  <= href_d;
            CMOS_CLKEN <= clken_d;
            CMOS_DATA  <= clken_d ? pix_d : '0;
            X_POS      <= href_d ? x_q : '0;
            Y_POS      <= (state_q == ST_ACTIVE) ? y_q : '0;

            // Frame-count update is delayed one cycle so it lands after the last VFP output cycle.
            done_q <= frame_end_d;
            if (done_q) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
`ifdef PATTERN_GEN_CHECKSUM_EN
            if (clken_d) begin
                acc_q <= acc_q + 32'(pix_d);
            end
            if (done_q) begin
                frame_checksum <= acc_q;
                acc_q          <= '0;
            end
`endif

            if (clken_d) begin
                x_q <= x_q + 16'd1;
                p_q <= p_q + CH_WIDTH'(1);
            end
            if (href_d) begin
                div_q <= (div_q == DIV_LAST) ? 5'd0 : div_q + 5'd1;
            end

            if (state_q != ST_IDLE) begin
                hcnt_q <= line_end_d ? 16'd0 : hcnt_q + 16'd1;
                // Line-end clears override the per-pixel increments above.
                if (line_end_d) begin
                    x_q    <= '0;
                    div_q  <= '0;
                    vcnt_q <= last_line_d ? 16'd0 : vcnt_q + 16'd1;
                    if (state_q == ST_ACTIVE) begin
                        y_q <= y_q + 16'd1;
                    end
                    if (last_line_d) begin
                        case (state_q)
                            ST_VSYNC:  state_q <= ST_VBP;
                            ST_VBP:    state_q <= ST_ACTIVE;
                            ST_ACTIVE: state_q <= ST_VFP;
                            default:   state_q <= ST_IDLE;
                        endcase
                    end
                end
            end

            if (start_d) begin
                state_q <= ST_VSYNC;
                hcnt_q  <= '0;
                vcnt_q  <= '0;
                x_q     <= '0;
                y_q     <= '0;
                div_q   <= '0;
                p_q     <= '0;
                mode_q  <= mode;
                solid_q <= solid_color;
            end
        end
    end

endmodule

// File: tb/tb_cmos_pattern_gen.sv
module tb_cmos_pattern_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        enable, enable3;
    logic [1:0]  mode, mode3;
    logic [23:0] solid;

    logic        vsync, href, clken;
    logic [23:0] data;
    logic [15:0] xpos, ypos, fcnt;
    logic        vsync3, href3, clken3;
    logic [23:0] data3;
    logic [15:0] xpos3, ypos3, fcnt3;
`ifdef PATTERN_GEN_CHECKSUM_EN
    logic [31:0] csum, csum3;
`endif

    cmos_pattern_gen #(
        .IMG_HDISP(16), .IMG_VDISP(4), .H_BLANK(4), .V_SYNC(1), .V_BP(2), .V_FP(1),
        .CH_NUM(3), .CH_WIDTH(8), .CLKEN_DIV(1)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_color(solid),
        .CMOS_VSYNC(vsync), .CMOS_HREF(href), .CMOS_CLKEN(clken), .CMOS_DATA(data),
        .X_POS(xpos), .Y_POS(ypos), .frame_cnt(fcnt)
`ifdef PATTERN_GEN_CHECKSUM_EN
        , .frame_checksum(csum)
`endif
    );

    cmos_pattern_gen #(
        .IMG_HDISP(16), .IMG_VDISP(4), .H_BLANK(4), .V_SYNC(1), .V_BP(2), .V_FP(1),
        .CH_NUM(3), .CH_WIDTH(8), .CLKEN_DIV(3)
    ) u_dut_div3 (
        .clk(clk), .rst(rst), .enable(enable3), .mode(mode3), .solid_color(24'h000000),
        .CMOS_VSYNC(vsync3), .CMOS_HREF(href3), .CMOS_CLKEN(clken3), .CMOS_DATA(data3),
        .X_POS(xpos3), .Y_POS(ypos3), .frame_cnt(fcnt3)
`ifdef PATTERN_GEN_CHECKSUM_EN
        , .frame_checksum(csum3)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected pixel k (CLKEN order) of a 16x4 frame.
    function automatic logic [23:0] exp_pix(input logic [1:0] m, input int k, input logic [23:0] sc);
        int          x, y, b;
        logic [2:0]  v;
        logic [23:0] r;
        x = k % 16;
        y = k / 16;
        r = '0;
        case (m)
            2'd0: begin
                b = (x * 8) / 16;
                v = 3'(7 - b);
                for (int c = 0; c < 3; c++) r[c*8 +: 8] = v[c] ? 8'hFF : 8'h00;
            end
            2'd1: r = {3{8'(x + y)}};
            2'd2: r = {8'(k + 2), 8'(k + 1), 8'(k)};
            default: r = sc;
        endcase
        return r;
    endfunction

    int          vs_cnt, href_first, href_cnt, ck_cnt, pix_bad, pos_bad, off_bad;
    logic [23:0] pix [64];

    // Observe one 160-cycle frame of u_dut starting at its first VSYNC cycle.
    // act 1: switch mode to 2 at cycle act_t; act 2: drop enable and switch mode to 3.
    task automatic run_frame(input logic [1:0] m, input logic [23:0] sc, input int act_t, input int act);
        vs_cnt = 0; href_first = -1; href_cnt = 0; ck_cnt = 0;
        pix_bad = 0; pos_bad = 0; off_bad = 0;
        for (int t = 0; t < 160; t++) begin
            if (t == act_t) begin
                if (act == 1) mode = 2'd2;
                if (act == 2) begin
                    enable = 1'b0;
                    mode   = 2'd3;
                end
            end
            if (vsync) vs_cnt++;
            if (href) begin
                href_cnt++;
                if (href_first < 0) href_first = t;
            end
            if (clken) begin
                if (ck_cnt < 64) begin
                    pix[ck_cnt] = data;
                    if (data !== exp_pix(m, ck_cnt, sc)) pix_bad++;
                    if (int'(xpos) != ck_cnt % 16 || int'(ypos) != ck_cnt / 16) pos_bad++;
                end
                ck_cnt++;
            end else if (data !== '0) begin
                off_bad++;
            end
            tick();
        end
    endtask

    initial begin
        int          hc3, ck3, gap3, off3, last_ck, idle_vs;
        logic [23:0] first3;
        logic [31:0] exp_cs, cs2;

        exp_cs = '0;
        for (int p = 0; p < 64; p++) exp_cs += 32'(p) + (32'(p + 1) << 8) + (32'(p + 2) << 16);
        cs2 = '0;

        rst = 1'b1; enable = 1'b0; enable3 = 1'b0; mode = 2'd0; mode3 = 2'd2; solid = '0;
        repeat (3) tick();
        chk("rst_vsync", {31'd0, vsync}, 32'd0);
        chk("rst_href", {31'd0, href}, 32'd0);
        chk("rst_data", {8'd0, data}, 32'd0);
        chk("rst_fcnt", {16'd0, fcnt}, 32'd0);
        rst = 1'b0;
        tick();

        // CLKEN_DIV=3: L=52, first active line spans cycles 156..207, HREF 160..207.
        enable3 = 1'b1;
        tick();
        chk("d3_vs_delay", {31'd0, vsync3}, 32'd0);
        tick();
        hc3 = 0; ck3 = 0; gap3 = 0; off3 = 0; last_ck = -1; first3 = '0;
        for (int t = 0; t < 208; t++) begin
            if (href3) hc3++;
            if (clken3) begin
                if (!href3) gap3++;
                if (last_ck >= 0 && t - last_ck != 3) gap3++;
                if (ck3 == 0) first3 = data3;
                last_ck = t;
                ck3++;
            end else if (data3 !== '0) begin
                off3++;
            end
            tick();
        end
        chk("d3_href_len", hc3, 48);
        chk("d3_clken_cnt", ck3, 16);
        chk("d3_clken_spacing", gap3, 0);
        chk("d3_data_between", off3, 0);
        chk("d3_first_pix", {8'd0, first3}, 32'h00020100);
        enable3 = 1'b0;

        // Frame 1: bars; mode input changes to 2 mid-frame and must not take effect.
        mode = 2'd0; enable = 1'b1;
        tick();
        chk("vs_rise_delay", {31'd0, vsync}, 32'd0);
        tick();
        run_frame(2'd0, 24'h0, 30, 1);
        chk("f1_vsync_len", vs_cnt, 20);
        chk("f1_href_first", href_first, 64);
        chk("f1_href_cnt", href_cnt, 64);
        chk("f1_clken_cnt", ck_cnt, 64);
        chk("f1_pix_x0", {8'd0, pix[0]}, 32'h00FFFFFF);
        chk("f1_pix_x1", {8'd0, pix[1]}, 32'h00FFFFFF);
        chk("f1_pix_x2", {8'd0, pix[2]}, 32'h00FFFF00);
        chk("f1_pix_x14", {8'd0, pix[14]}, 32'h00000000);
        chk("f1_pix_x15", {8'd0, pix[15]}, 32'h00000000);
        chk("f1_pix_all", pix_bad, 0);
        chk("f1_xy_pos", pos_bad, 0);
        chk("f1_data_off", off_bad, 0);
        chk("f1_fcnt", {16'd0, fcnt}, 32'd1);
        chk("f2_vsync_b2b", {31'd0, vsync}, 32'd1);

        // Frame 2: counter pattern.
        run_frame(2'd2, 24'h0, -1, 0);
        chk("f2_first_pix", {8'd0, pix[0]}, 32'h00020100);
        chk("f2_last_pix", {8'd0, pix[63]}, 32'h0041403F);
        chk("f2_pix_all", pix_bad, 0);
        chk("f2_fcnt", {16'd0, fcnt}, 32'd2);
`ifdef PATTERN_GEN_CHECKSUM_EN
        cs2 = csum;
        chk("f2_checksum", csum, exp_cs);
`endif

        // Frame 3: counter again; enable drops and mode changes at cycle 80.
        run_frame(2'd2, 24'h0, 80, 2);
        chk("f3_first_pix", {8'd0, pix[0]}, 32'h00020100);
        chk("f3_last_pix", {8'd0, pix[63]}, 32'h0041403F);
        chk("f3_pix_all", pix_bad, 0);
        chk("f3_clken_cnt", ck_cnt, 64);
        chk("f3_fcnt", {16'd0, fcnt}, 32'd3);
`ifdef PATTERN_GEN_CHECKSUM_EN
        chk("f3_checksum_same", csum, cs2);
`endif
        chk("idle_vsync", {31'd0, vsync}, 32'd0);
        chk("idle_href", {31'd0, href}, 32'd0);
        chk("idle_data", {8'd0, data}, 32'd0);
        chk("idle_pos", {xpos, ypos}, 32'd0);
        idle_vs = 0;
        for (int t = 0; t < 40; t++) begin
            if (vsync || href || clken) idle_vs++;
            tick();
        end
        chk("idle_stays", idle_vs, 0);

        // Frame 4: solid colour.
        solid = 24'h123456; enable = 1'b1;
        tick();
        tick();
        run_frame(2'd3, 24'h123456, -1, 0);
        chk("f4_clken_cnt", ck_cnt, 64);
        chk("f4_pix_solid", pix_bad, 0);
        chk("f4_fcnt", {16'd0, fcnt}, 32'd4);
`ifdef PATTERN_GEN_CHECKSUM_EN
        chk("f4_checksum", csum, 32'h048D1580);
`endif

        // Frame 5 runs back-to-back; reset it mid-ACTIVE (cycle 110 is inside HREF).
        repeat (110) tick();
        chk("pre_rst_href", {31'd0, href}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_href", {31'd0, href}, 32'd0);
        chk("mid_rst_clken", {31'd0, clken}, 32'd0);
        chk("mid_rst_data", {8'd0, data}, 32'd0);
        chk("mid_rst_pos", {xpos, ypos}, 32'd0);
        chk("mid_rst_fcnt", {16'd0, fcnt}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_vs_delay", {31'd0, vsync}, 32'd0);
        tick();
        chk("rst_new_fcnt", {16'd0, fcnt}, 32'd0);
        run_frame(2'd3, 24'h123456, -1, 0);
        chk("f6_vsync_len", vs_cnt, 20);
        chk("f6_clken_cnt", ck_cnt, 64);
        chk("f6_pix_solid", pix_bad, 0);
        chk("f6_fcnt", {16'd0, fcnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
